// File: rtl/uart_rx_deframer19.sv
// UART19 receive deframer: 16x oversampled start/data/parity/stop capture.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting over ticks 6/7/8.
module uart_rx_deframer19 #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock19,
  input  logic                 reset,
  input  logic                 baud_clk19,
  input  logic                 rxd19,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t               r_state;
  state_t               w_state_nx;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxd_s;
  logic [3:0]           r_tick;
  logic [2:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_pacc;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 w_bit;
  logic                 w_mid;
  logic                 w_done;
  logic                 w_ferr_nx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_pe;
  logic                 r_ovr;

  always_ff @(posedge clock19 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd19;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s = r_sync2;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [3:0] SMP_TICK = 4'd8;
  logic r_s6;
  logic r_s7;

  always_ff @(posedge clock19 or negedge reset) begin
    if (!reset) begin
      r_s6 <= 1'b1;
      r_s7 <= 1'b1;
    end else if (baud_clk19) begin
      if (r_tick == 4'd6) r_s6 <= w_rxd_s;
      if (r_tick == 4'd7) r_s7 <= w_rxd_s;
    end
  end

  assign w_bit = (r_s6 & r_s7) | (r_s6 & w_rxd_s) |
                 (r_s7 & w_rxd_s);
`else
  localparam logic [3:0] SMP_TICK = 4'd7;
  assign w_bit = w_rxd_s;
`endif

  assign w_mid     = baud_clk19 && (r_tick == SMP_TICK);
  assign w_ferr_nx = r_ferr | ~w_bit;

  always_comb begin
    w_state_nx = r_state;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (baud_clk19 && !w_rxd_s) w_state_nx = S_START;
      end
      S_START: begin
        if (w_mid) w_state_nx = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_mid && r_bitcnt == LAST_DATA)
          w_state_nx = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_mid) w_state_nx = S_STOP;
      end
      S_STOP: begin
        if (w_mid && r_bitcnt == LAST_STOP) begin
          w_done     = 1'b1;
          w_state_nx = w_ferr_nx ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (baud_clk19 && w_rxd_s) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock19 or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // tick counter parks at 0 in IDLE so START begins from a cleared count
  always_ff @(posedge clock19 or negedge reset) begin
    if (!reset) begin
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_pacc   <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        r_tick   <= '0;
        r_bitcnt <= '0;
        r_pacc   <= 1'b0;
        r_perr   <= 1'b0;
        r_ferr   <= 1'b0;
      end else if (baud_clk19) begin
        r_tick <= r_tick + 4'd1;
      end
      if (w_mid) begin
        case (r_state)
          S_DATA: begin
            r_shift  <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_pacc   <= r_pacc ^ w_bit;
            r_bitcnt <= (r_bitcnt == LAST_DATA) ? 3'd0
                                                : r_bitcnt + 3'd1;
          end
          S_PARITY: begin
            r_perr <= (PARITY_MODE == 1) ? ~(r_pacc ^ w_bit)
                                         : (r_pacc ^ w_bit);
          end
          S_STOP: begin
            r_ferr   <= w_ferr_nx;
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock19 or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done && (!r_valid || rx_ready)) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_fe    <= w_ferr_nx;
        r_pe    <= r_perr;
      end else begin
        if (w_done) r_ovr <= 1'b1;
        if (rx_ready) r_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign rx_frame_err  = r_fe;
  assign rx_parity_err = r_pe;
  assign rx_overrun    = r_ovr;
  assign rx_busy       = (r_state != S_IDLE);

endmodule
